// File: rtl/sys_array_pkg.sv
// Shared types and sizing helpers for the systolic-array stream controller.
// Word counts and counter widths are derived from the array geometry parameters.
package sys_array_pkg;

    typedef enum logic [2:0] {
        ST_RX_W  = 3'd0,
        ST_RX_A  = 3'd1,
        ST_FRST  = 3'd2,
        ST_LOAD  = 3'd3,
        ST_START = 3'd4,
        ST_WAIT  = 3'd5,
        ST_TX    = 3'd6
    } state_e;

    function automatic int nw_words(input int w_w, input int w_l);
        return w_w * w_l;
    endfunction

    function automatic int na_words(input int a_w, input int a_l);
        return a_w * a_l;
    endfunction

    function automatic int nr_words(input int w_w, input int a_l);
        return w_w * a_l;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        return max2(max2(a, b), c);
    endfunction

    // Bits needed to count 0..n-1, never less than one.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int idx_width(input int nw, input int na, input int nr);
        return cnt_width(max3(nw, na, nr));
    endfunction

endpackage

// File: rtl/sys_array_result_tx.sv
// Result buffer and serialiser: captures the whole result matrix on a load strobe,
// then streams it row-major on a valid/ready port with a last marker and done pulse.
module sys_array_result_tx
    import sys_array_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ROWS       = 2,
    parameter int COLS       = 2
) (
    input  logic                                      clk,
    input  logic                                      srst,
    input  logic                                      load,
    input  logic [ROWS-1:0][COLS-1:0][2*DATA_WIDTH-1:0] load_data,
    output logic                                      m_valid,
    input  logic                                      m_ready,
    output logic [2*DATA_WIDTH-1:0]                   m_data,
    output logic                                      m_last,
    output logic                                      done
);

    localparam int NR   = nr_words(ROWS, COLS);
    localparam int RW   = 2 * DATA_WIDTH;
    localparam int IX_W = cnt_width(NR);
    localparam logic [IX_W-1:0] LAST_IDX = IX_W'(NR - 1);

    logic [RW-1:0]   buf_q [NR];
    logic [RW-1:0]   buf_d [NR];
    logic [IX_W-1:0] idx_q, idx_d, idx_inc;
    logic [RW-1:0]   data_q, data_d;
    logic            valid_q, valid_d;
    logic            last_q, last_d;
    logic            hs;

    genvar gi, gj;
    generate
        for (gi = 0; gi < ROWS; gi++) begin : g_row
            for (gj = 0; gj < COLS; gj++) begin : g_col
                assign buf_d[gi*COLS + gj] = load ? load_data[gi][gj] : buf_q[gi*COLS + gj];
            end
        end
    endgenerate

    assign idx_inc = idx_q + 1'b1;
    assign hs      = valid_q && m_ready;

    always_comb begin
        valid_d = valid_q;
        idx_d   = idx_q;
        data_d  = data_q;
        last_d  = last_q;
        if (load) begin
            valid_d = 1'b1;
            idx_d   = '0;
            data_d  = load_data[0][0];
            last_d  = (LAST_IDX == '0);
        end else if (hs) begin
            if (last_q) begin
                // Hold the final word on m_data; only valid drops.
                valid_d = 1'b0;
                idx_d   = '0;
                last_d  = 1'b0;
            end else begin
                idx_d  = idx_inc;
                data_d = buf_q[idx_inc];
                last_d = (idx_inc == LAST_IDX);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            valid_q <= 1'b0;
            idx_q   <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
            for (int i = 0; i < NR; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            last_q  <= last_d;
            buf_q   <= buf_d;
        end
    end

    assign m_valid = valid_q;
    assign m_data  = data_q;
    assign m_last  = last_q;
    assign done    = hs && last_q;

endmodule

// File: rtl/sys_array_stream_ctrl.sv
// Host-side sequencer: deserialises weights and data into the fetcher operand buses,
// runs one fetcher job (reset, load, start, wait) and streams the results back out.
module sys_array_stream_ctrl
    import sys_array_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ARRAY_W_W  = 2,
    parameter int ARRAY_W_L  = 5,
    parameter int ARRAY_A_W  = 5,
    parameter int ARRAY_A_L  = 2,
    parameter int TIMEOUT    = 255
) (
    input  logic                                                 clk,
    input  logic                                                 reset,
    input  logic                                                 s_valid,
    output logic                                                 s_ready,
    input  logic [DATA_WIDTH-1:0]                                s_data,
    output logic                                                 m_valid,
    input  logic                                                 m_ready,
    output logic [2*DATA_WIDTH-1:0]                              m_data,
    output logic                                                 m_last,
    output logic                                                 busy,
    output logic                                                 error,
    output logic                                                 fetch_rst_n,
    output logic                                                 load_params,
    output logic                                                 start_comp,
    output logic [ARRAY_W_W-1:0][ARRAY_W_L-1:0][DATA_WIDTH-1:0]  input_data_w,
    output logic [ARRAY_A_W-1:0][ARRAY_A_L-1:0][DATA_WIDTH-1:0]  input_data_b,
    input  logic                                                 fetch_ready,
    input  logic [ARRAY_W_W-1:0][ARRAY_A_L-1:0][2*DATA_WIDTH-1:0] fetch_out_data
);

    localparam int ROW_W = cnt_width(max2(ARRAY_W_W, ARRAY_A_W));
    localparam int COL_W = cnt_width(max2(ARRAY_W_L, ARRAY_A_L));
    localparam int TMR_W = cnt_width(TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    state_e state_q, state_d;

    logic [ROW_W-1:0] row_q, row_d, row_last;
    logic [COL_W-1:0] col_q, col_d, col_last;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             error_q, error_d;
    logic             fetch_rst_n_q, fetch_rst_n_d;
    logic             s_hs, wr_w, wr_a, phase_done, timeout_hit;
    logic             tx_load, tx_done;

    logic [ARRAY_W_W-1:0][ARRAY_W_L-1:0][DATA_WIDTH-1:0] w_bus_q, w_bus_d;
    logic [ARRAY_A_W-1:0][ARRAY_A_L-1:0][DATA_WIDTH-1:0] a_bus_q, a_bus_d;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RX_W;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RX_W:  if (phase_done) state_d = ST_RX_A;
            ST_RX_A:  if (phase_done) state_d = ST_FRST;
            ST_FRST:  state_d = ST_LOAD;
            ST_LOAD:  state_d = ST_START;
            ST_START: state_d = ST_WAIT;
            ST_WAIT: begin
                if (fetch_ready) begin
                    state_d = ST_TX;
                end else if (timer_q == TMR_LAST) begin
                    state_d = ST_RX_W;
                end
            end
            ST_TX:    if (tx_done) state_d = ST_RX_W;
            default:  state_d = ST_RX_W;
        endcase
    end

    // ---------------- FSM: outputs decoded from state ----------------
    always_comb begin
        s_ready     = 1'b0;
        busy        = 1'b0;
        load_params = 1'b0;
        start_comp  = 1'b0;
        case (state_q)
            ST_RX_W, ST_RX_A:        s_ready = 1'b1;
            ST_FRST, ST_WAIT, ST_TX: busy    = 1'b1;
            ST_LOAD: begin
                busy        = 1'b1;
                load_params = 1'b1;
            end
            ST_START: begin
                busy       = 1'b1;
                start_comp = 1'b1;
            end
            default: ;
        endcase
    end

    // ---------------- Operand deserialisation ----------------
    assign s_hs = s_ready && s_valid;
    assign wr_w = s_hs && (state_q == ST_RX_W);
    assign wr_a = s_hs && (state_q == ST_RX_A);

    assign row_last = (state_q == ST_RX_W) ? ROW_W'(ARRAY_W_W - 1) : ROW_W'(ARRAY_A_W - 1);
    assign col_last = (state_q == ST_RX_W) ? COL_W'(ARRAY_W_L - 1) : COL_W'(ARRAY_A_L - 1);
    assign phase_done = s_hs && (row_q == row_last) && (col_q == col_last);

    // One row/column cursor serves both phases; it wraps to zero at each phase end.
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (s_hs) begin
            if (col_q == col_last) begin
                col_d = '0;
                row_d = (row_q == row_last) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    genvar gi, gj;
    generate
        for (gi = 0; gi < ARRAY_W_W; gi++) begin : g_w_row
            for (gj = 0; gj < ARRAY_W_L; gj++) begin : g_w_col
                assign w_bus_d[gi][gj] = (wr_w && row_q == ROW_W'(gi) && col_q == COL_W'(gj))
                                         ? s_data : w_bus_q[gi][gj];
            end
        end
        for (gi = 0; gi < ARRAY_A_W; gi++) begin : g_a_row
            for (gj = 0; gj < ARRAY_A_L; gj++) begin : g_a_col
                assign a_bus_d[gi][gj] = (wr_a && row_q == ROW_W'(gi) && col_q == COL_W'(gj))
                                         ? s_data : a_bus_q[gi][gj];
            end
        end
    endgenerate

    // ---------------- Job control: timer, sticky error, fetcher reset ----------------
    assign timeout_hit = (state_q == ST_WAIT) && !fetch_ready && (timer_q == TMR_LAST);

    always_comb begin
        // Timer runs from START, so the timeout window includes the start cycle.
        timer_d       = ((state_q == ST_START) || (state_q == ST_WAIT)) ? timer_q + 1'b1 : '0;
        error_d       = error_q || timeout_hit;
        fetch_rst_n_d = (state_d != ST_FRST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            row_q         <= '0;
            col_q         <= '0;
            timer_q       <= '0;
            error_q       <= 1'b0;
            fetch_rst_n_q <= 1'b0;
            w_bus_q       <= '0;
            a_bus_q       <= '0;
        end else begin
            row_q         <= row_d;
            col_q         <= col_d;
            timer_q       <= timer_d;
            error_q       <= error_d;
            fetch_rst_n_q <= fetch_rst_n_d;
            w_bus_q       <= w_bus_d;
            a_bus_q       <= a_bus_d;
        end
    end

    assign error        = error_q;
    assign fetch_rst_n  = fetch_rst_n_q;
    assign input_data_w = w_bus_q;
    assign input_data_b = a_bus_q;

    // ---------------- Result capture and serialisation ----------------
    assign tx_load = (state_q == ST_WAIT) && fetch_ready;

    sys_array_result_tx #(
        .DATA_WIDTH (DATA_WIDTH),
        .ROWS       (ARRAY_W_W),
        .COLS       (ARRAY_A_L)
    ) u_result_tx (
        .clk       (clk),
        .srst      (reset),
        .load      (tx_load),
        .load_data (fetch_out_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last),
        .done      (tx_done)
    );

endmodule

// File: tb/tb_sys_array_stream_ctrl.sv
// Directed bench for sys_array_stream_ctrl with a behavioural fetcher model
// (sticky ready, cleared by reset_n) standing in for sys_array_fetcher.
module tb_sys_array_stream_ctrl;

    localparam int DW  = 8;
    localparam int WW  = 2;
    localparam int WL  = 5;
    localparam int AW  = 5;
    localparam int AL  = 2;
    localparam int TMO = 255;

    logic clk = 1'b0;
    logic reset, s_valid, s_ready, m_valid, m_ready, m_last;
    logic busy, error, fetch_rst_n, load_params, start_comp, fetch_ready;
    logic [DW-1:0]   s_data;
    logic [2*DW-1:0] m_data;
    logic [WW-1:0][WL-1:0][DW-1:0]   input_data_w;
    logic [AW-1:0][AL-1:0][DW-1:0]   input_data_b;
    logic [WW-1:0][AL-1:0][2*DW-1:0] fetch_out_data;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] stim [20];
    logic stub_dead;

    always #5 clk = ~clk;

    sys_array_stream_ctrl #(
        .DATA_WIDTH (DW), .ARRAY_W_W (WW), .ARRAY_W_L (WL),
        .ARRAY_A_W  (AW), .ARRAY_A_L (AL), .TIMEOUT   (TMO)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .s_data         (s_data),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_data         (m_data),
        .m_last         (m_last),
        .busy           (busy),
        .error          (error),
        .fetch_rst_n    (fetch_rst_n),
        .load_params    (load_params),
        .start_comp     (start_comp),
        .input_data_w   (input_data_w),
        .input_data_b   (input_data_b),
        .fetch_ready    (fetch_ready),
        .fetch_out_data (fetch_out_data)
    );

    // ---------------- Fetcher model ----------------
    logic [WW-1:0][WL-1:0][DW-1:0] f_w;
    logic [AW-1:0][AL-1:0][DW-1:0] f_b;
    logic f_run;
    int   f_cnt;

    function automatic logic [15:0] dot(input int r, input int c);
        logic [15:0] acc;
        acc = '0;
        for (int k = 0; k < WL; k++) acc = acc + 16'(f_w[r][k]) * 16'(f_b[k][c]);
        return acc;
    endfunction

    always @(posedge clk) begin
        if (!fetch_rst_n) begin
            fetch_ready    <= 1'b0;
            fetch_out_data <= '0;
            f_run          <= 1'b0;
            f_cnt          <= 0;
        end else begin
            if (load_params) begin
                f_w <= input_data_w;
                f_b <= input_data_b;
            end
            if (start_comp) begin
                f_run <= 1'b1;
                f_cnt <= 0;
            end else if (f_run && !stub_dead) begin
                if (f_cnt == 3) begin
                    f_run       <= 1'b0;
                    fetch_ready <= 1'b1;
                    for (int r = 0; r < WW; r++)
                        for (int c = 0; c < AL; c++)
                            fetch_out_data[r][c] <= dot(r, c);
                end else begin
                    f_cnt <= f_cnt + 1;
                end
            end
        end
    end

    // ---------------- Stimulus helpers ----------------
    task automatic set_stim(input int wmul);
        for (int i = 0; i < 10; i++) begin
            stim[i]      = 8'((i + 1) * wmul);
            stim[10 + i] = 8'(i + 1);
        end
    endtask

    // Returns at the negedge of the cycle after the 20th handshake.
    task automatic send_job(input int gap, input string tag);
        int bound;
        logic stuck;
        stuck = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (gap != 0) begin
                s_valid = 1'b0;
                @(negedge clk);
            end
            s_valid = 1'b1;
            s_data  = stim[i];
            bound = 0;
            while (s_ready !== 1'b1 && bound < 100) begin
                @(negedge clk);
                bound++;
            end
            if (bound >= 100) stuck = 1'b1;
            @(negedge clk);
        end
        s_valid = 1'b0;
        $display("tx %s: 20 operand words sent", tag);
        n_cmp++;
        if (stuck) begin
            n_bad++;
            $display("FAIL %s_accept: s_ready stuck at %b, required 1", tag, s_ready);
        end
    endtask

    task automatic recv_job(input int stall, input string tag,
                            input logic [15:0] e0, input logic [15:0] e1,
                            input logic [15:0] e2, input logic [15:0] e3);
        logic [15:0] exp_w [4];
        logic [15:0] ref_d;
        logic ref_l, prev1, prev2, hold_bad;
        int bound;
        exp_w[0] = e0; exp_w[1] = e1; exp_w[2] = e2; exp_w[3] = e3;
        prev1 = 1'b0;
        prev2 = 1'b0;
        bound = 0;
        while (m_valid !== 1'b1 && bound < 400) begin
            prev2 = prev1;
            prev1 = fetch_ready;
            @(negedge clk);
            bound++;
        end
        n_cmp++;
        if (bound >= 400) begin
            n_bad++;
            $display("FAIL %s_wait: m_valid=%b, required 1 within 400 cycles", tag, m_valid);
            return;
        end
        n_cmp++;
        if (prev1 !== 1'b1 || prev2 !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_latency: ready history %b%b before m_valid, required 01", tag, prev2, prev1);
        end
        for (int k = 0; k < 4; k++) begin
            if (stall != 0) begin
                m_ready  = 1'b0;
                ref_d    = m_data;
                ref_l    = m_last;
                hold_bad = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    if (m_valid !== 1'b1 || m_data !== ref_d || m_last !== ref_l) hold_bad = 1'b1;
                end
                n_cmp++;
                if (hold_bad) begin
                    n_bad++;
                    $display("FAIL %s_hold%0d: data=%0d valid=%b, required %0d held", tag, k, m_data, m_valid, ref_d);
                end
            end
            m_ready = 1'b1;
            $display("rx %s word %0d data=%0d last=%b", tag, k, m_data, m_last);
            n_cmp++;
            if (m_valid !== 1'b1 || m_data !== exp_w[k]) begin
                n_bad++;
                $display("FAIL %s_data%0d: got %0d (valid %b), required %0d", tag, k, m_data, m_valid, exp_w[k]);
            end
            n_cmp++;
            if (m_last !== (k == 3)) begin
                n_bad++;
                $display("FAIL %s_last%0d: got %b, required %b", tag, k, m_last, (k == 3));
            end
            @(negedge clk);
            m_ready = 1'b0;
        end
        n_cmp++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_done: valid=%b s_ready=%b busy=%b, required 0 1 0", tag, m_valid, s_ready, busy);
        end
    endtask

    // ---------------- Tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (s_ready !== 1'b1 || m_valid !== 1'b0 || busy !== 1'b0 || error !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_ctl: s_ready=%b m_valid=%b busy=%b error=%b, required 1 0 0 0", s_ready, m_valid, busy, error);
        end
        n_cmp++;
        if (fetch_rst_n !== 1'b0 || load_params !== 1'b0 || start_comp !== 1'b0 || m_last !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_fetch: rst_n=%b load=%b start=%b last=%b, required 0 0 0 0", fetch_rst_n, load_params, start_comp, m_last);
        end
        n_cmp++;
        if (input_data_w !== '0 || input_data_b !== '0 || m_data !== '0) begin
            n_bad++;
            $display("FAIL reset_bus: w=%h b=%h m_data=%h, required all 0", input_data_w, input_data_b, m_data);
        end
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (fetch_rst_n !== 1'b1 || s_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_release: rst_n=%b s_ready=%b, required 1 1", fetch_rst_n, s_ready);
        end
    endtask

    task automatic test_nominal();
        set_stim(1);
        send_job(0, "nominal");
        n_cmp++;
        if (fetch_rst_n !== 1'b0 || s_ready !== 1'b0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL nominal_frst: rst_n=%b s_ready=%b busy=%b, required 0 0 1", fetch_rst_n, s_ready, busy);
        end
        @(negedge clk);
        n_cmp++;
        if (load_params !== 1'b1 || fetch_rst_n !== 1'b1) begin
            n_bad++;
            $display("FAIL nominal_load: load=%b rst_n=%b, required 1 1", load_params, fetch_rst_n);
        end
        n_cmp++;
        if (input_data_w[0][0] !== 8'd1 || input_data_w[1][4] !== 8'd10 || input_data_w[0][4] !== 8'd5) begin
            n_bad++;
            $display("FAIL nominal_wbus: w00=%0d w04=%0d w14=%0d, required 1 5 10", input_data_w[0][0], input_data_w[0][4], input_data_w[1][4]);
        end
        n_cmp++;
        if (input_data_b[0][1] !== 8'd2 || input_data_b[2][0] !== 8'd5 || input_data_b[4][1] !== 8'd10) begin
            n_bad++;
            $display("FAIL nominal_abus: b01=%0d b20=%0d b41=%0d, required 2 5 10", input_data_b[0][1], input_data_b[2][0], input_data_b[4][1]);
        end
        @(negedge clk);
        n_cmp++;
        if (start_comp !== 1'b1 || load_params !== 1'b0) begin
            n_bad++;
            $display("FAIL nominal_start: start=%b load=%b, required 1 0", start_comp, load_params);
        end
        recv_job(0, "nominal", 16'd95, 16'd110, 16'd220, 16'd260);
    endtask

    task automatic test_gapped();
        set_stim(1);
        send_job(1, "gapped");
        n_cmp++;
        if (fetch_rst_n !== 1'b0) begin
            n_bad++;
            $display("FAIL gapped_frst: rst_n=%b one cycle after last word, required 0", fetch_rst_n);
        end
        recv_job(0, "gapped", 16'd95, 16'd110, 16'd220, 16'd260);
    endtask

    task automatic test_backpressure();
        set_stim(1);
        send_job(0, "bp");
        recv_job(1, "bp", 16'd95, 16'd110, 16'd220, 16'd260);
    endtask

    task automatic test_back_to_back();
        set_stim(1);
        send_job(0, "b2b_a");
        recv_job(0, "b2b_a", 16'd95, 16'd110, 16'd220, 16'd260);
        set_stim(2);
        send_job(0, "b2b_b");
        n_cmp++;
        if (fetch_rst_n !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_frst: rst_n=%b, required 0", fetch_rst_n);
        end
        recv_job(0, "b2b_b", 16'd190, 16'd220, 16'd440, 16'd520);
    endtask

    task automatic test_timeout();
        logic early_err, saw_valid;
        stub_dead = 1'b1;
        set_stim(1);
        send_job(0, "timeout");
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (start_comp !== 1'b1) begin
            n_bad++;
            $display("FAIL timeout_start: start=%b, required 1", start_comp);
        end
        // Offer a junk word while busy; it must not be taken.
        s_valid   = 1'b1;
        s_data    = 8'hEE;
        early_err = 1'b0;
        saw_valid = 1'b0;
        for (int k = 1; k <= 254; k++) begin
            @(negedge clk);
            if (error !== 1'b0 || busy !== 1'b1) early_err = 1'b1;
            if (m_valid !== 1'b0) saw_valid = 1'b1;
        end
        s_valid = 1'b0;
        n_cmp++;
        if (early_err) begin
            n_bad++;
            $display("FAIL timeout_early: error=%b busy=%b before START+255, required 0 1", error, busy);
        end
        @(negedge clk);
        if (m_valid !== 1'b0) saw_valid = 1'b1;
        n_cmp++;
        if (error !== 1'b1 || s_ready !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_flag: error=%b s_ready=%b busy=%b at START+255, required 1 1 0", error, s_ready, busy);
        end
        n_cmp++;
        if (saw_valid) begin
            n_bad++;
            $display("FAIL timeout_mvalid: m_valid seen 1, required 0");
        end
        n_cmp++;
        if (input_data_w[0][0] !== 8'd1 || input_data_b[4][1] !== 8'd10) begin
            n_bad++;
            $display("FAIL timeout_noconsume: w00=%0d b41=%0d, required 1 10", input_data_w[0][0], input_data_b[4][1]);
        end
        stub_dead = 1'b0;
        send_job(0, "recover");
        recv_job(0, "recover", 16'd95, 16'd110, 16'd220, 16'd260);
        n_cmp++;
        if (error !== 1'b1) begin
            n_bad++;
            $display("FAIL timeout_sticky: error=%b, required 1", error);
        end
    endtask

    task automatic test_reset_mid_tx();
        int bound;
        set_stim(1);
        send_job(0, "midtx");
        bound = 0;
        while (m_valid !== 1'b1 && bound < 400) begin
            @(negedge clk);
            bound++;
        end
        m_ready = 1'b1;
        $display("rx midtx word 0 data=%0d last=%b", m_data, m_last);
        @(negedge clk);
        m_ready = 1'b0;
        n_cmp++;
        if (m_valid !== 1'b1 || m_data !== 16'd110) begin
            n_bad++;
            $display("FAIL midtx_word1: got %0d (valid %b), required 110", m_data, m_valid);
        end
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1 || error !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL midtx_ctl: m_valid=%b s_ready=%b error=%b busy=%b, required 0 1 0 0", m_valid, s_ready, error, busy);
        end
        n_cmp++;
        if (input_data_w !== '0 || input_data_b !== '0 || m_data !== '0 || fetch_rst_n !== 1'b0) begin
            n_bad++;
            $display("FAIL midtx_clear: w=%h b=%h m_data=%0d rst_n=%b, required 0 0 0 0", input_data_w, input_data_b, m_data, fetch_rst_n);
        end
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (fetch_rst_n !== 1'b1 || s_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL midtx_release: rst_n=%b s_ready=%b, required 1 1", fetch_rst_n, s_ready);
        end
    endtask

    initial begin
        reset     = 1'b1;
        s_valid   = 1'b0;
        s_data    = '0;
        m_ready   = 1'b0;
        stub_dead = 1'b0;
        test_reset();
        test_nominal();
        test_gapped();
        test_backpressure();
        test_back_to_back();
        test_timeout();
        test_reset_mid_tx();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000, required completion");
        $fatal(1);
    end

endmodule

// File: doc/sys_array_stream_ctrl.md
# sys_array_stream_ctrl

Host-side sequencer for the systolic multiplier, sitting between a word-serial host stream and `sys_array_fetcher`. It deserialises a weight matrix and a data matrix from a valid/ready stream into the fetcher's parallel operand buses, then drives the fetcher through one job: reset, `load_params` pulse, then `start_comp` pulse. It waits for the fetcher's `ready`, captures `out_data`, and serialises the result matrix back out on a second valid/ready stream.

## Interface
- `DATA_WIDTH`, 8, operand width; results are `2*DATA_WIDTH`
- `ARRAY_W_W`, 2, weight rows
- `ARRAY_W_L`, 5, weight columns
- `ARRAY_A_W`, 5, data rows
- `ARRAY_A_L`, 2, data columns
- `TIMEOUT`, 255, maximum WAIT cycles before error
- `clk`  in  1  single clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high
- `s_valid`  in  1  operand word valid
- `s_ready`  out  1  operand word accepted when `s_valid && s_ready`
- `s_data`  in  DATA_WIDTH  operand word
- `m_valid`  out  1  result word valid
- `m_ready`  in  1  downstream accepts result
- `m_data`  out  2*DATA_WIDTH  result word
- `m_last`  out  1  marks final result word of a job
- `busy`  out  1  high in FRST..TX
- `error`  out  1  sticky timeout flag
- `fetch_rst_n`  out  1  drives fetcher `reset_n`
- `load_params`  out  1  to fetcher
- `start_comp`  out  1  to fetcher
- `input_data_w`  out  [ARRAY_W_W][ARRAY_W_L][DATA_WIDTH]  to fetcher
- `input_data_b`  out  [ARRAY_A_W][ARRAY_A_L][DATA_WIDTH]  to fetcher
- `fetch_ready`  in  1  fetcher `ready`
- `fetch_out_data`  in  [ARRAY_W_W][ARRAY_A_L][2*DATA_WIDTH]  fetcher `out_data`

## Operation
- Word counts: `NW = ARRAY_W_W*ARRAY_W_L`, `NA = ARRAY_A_W*ARRAY_A_L`, `NR = ARRAY_W_W*ARRAY_A_L`.
- Stream order is row-major:
  - Weights first: word k goes to `input_data_w[k/ARRAY_W_L][k%ARRAY_W_L]`.
  - Data next: word k goes to `input_data_b[k/ARRAY_A_L][k%ARRAY_A_L]`.
  - Results: word k is `fetch_out_data[k/ARRAY_A_L][k%ARRAY_A_L]`.
- FSM:
  - RX_W: `s_ready=1`; count NW accepted words, then go to RX_A.
  - RX_A: `s_ready=1`; count NA accepted words, then go to FRST.
  - FRST: one cycle, `fetch_rst_n=0`. This clears the fetcher's sticky `ready`, so a stale `ready` from a prior job is never seen.
  - LOAD: one cycle, `load_params=1`.
  - START: one cycle, `start_comp=1`.
  - WAIT: capture `fetch_out_data` into the result buffer in the first cycle with `fetch_ready=1`, then go to TX. If `TIMEOUT` cycles pass without `fetch_ready`, set `error=1` and go to RX_W with no results emitted.
  - TX: `m_valid=1`. Index advances on each `m_ready` handshake. `m_last=1` on word NR-1. After the last handshake, go to RX_W.
- `s_ready=0` in all states other than RX_W/RX_A. Words offered there are not consumed.
- Operand buses hold their last written value until overwritten; they are stable from FRST through WAIT.
- Results are truncated to `2*DATA_WIDTH`; the block performs no arithmetic.
- `error` clears only on `reset`. A new job is still accepted after an error.

## Timing
- Reset values:
  - FSM state RX_W; `s_ready=1` from the first cycle after reset.
  - `m_valid`, `m_last`, `m_data`, `busy`, `error`, `load_params`, `start_comp` are all 0; operand buses and result buffer are 0.
  - `fetch_rst_n=0`, rising to 1 the cycle after `reset` deasserts.
- All outputs are registered or decoded directly from state; there are no combinational paths from `s_valid` or `m_ready` to outputs.
- Last data handshake at cycle t: FRST at t+1, LOAD at t+2, START at t+3, WAIT from t+4.
- Result capture: `fetch_ready` high at cycle u gives `m_valid=1` at u+1.
- `m_valid` backpressure: `m_data` and `m_last` hold stable while `m_ready=0`.
- After the last result handshake at v, `s_ready=1` at v+1.
- A `reset` in any state aborts immediately: next cycle is RX_W with all reset values, and the fetcher is reset one cycle.

## Structure
- `sys_array_pkg`: state enum, `NW`/`NA`/`NR` localparam functions, index width `$clog2(max(NW,NA,NR))`.
- One natural sub-module, `sys_array_result_tx`: result buffer plus serialiser (load strobe, m_* handshake, done pulse).

## Test plan
- Nominal job, default params, fetcher instantiated:
  - Stimulus: weights 1..10, data 1..10.
  - Required response: stream 95, 110, 220, 260, with `m_last` on 260 only; `busy` low afterwards.
- Gapped input: `s_valid` toggled every other cycle → same results; FRST occurs exactly 1 cycle after the 20th accepted word.
- Output backpressure: `m_ready` low 3 cycles per word → each word held stable, no word lost or duplicated.
- Back-to-back jobs, second job's weights doubled (2..20) → 190, 220, 440, 520; stale `ready` not used (`fetch_rst_n` pulses low).
- Timeout: stubbed `fetch_ready` tied 0 → `error=1` at START+255 cycles; `m_valid` never asserts; RX_W re-entered.
- Reset mid-TX after word 1 → `m_valid=0` next cycle, `s_ready=1`, `error=0`, buses cleared.
